alu181_nibble_seq: RTL and testbench

Multi-cycle sequencer that performs a (4·NIBBLES)-bit operation on one combinational `alu74181` nibble slice, processing one nibble per clock from LSB to MSB. It threads the carry between nibbles through a carry-out helper. It sits directly upstream of the `alu74181` instance, owns it, and feeds it `s`, `M`, `ci`, `a`, `b` each cycle. It collects the slice's `y` into a wide result register with carry-out and zero flag.

---
 rtl/alu181_pkg.sv | 16 +
 rtl/alu181_carry.sv | 21 ++
 rtl/alu74181.sv | 26 ++
 rtl/alu181_nibble_seq.sv | 131 +++++++++++++
 tb/tb_alu181_nibble_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu181_pkg.sv
// Shared types and function-code constants for the nibble-serial 74181 sequencer.
package alu181_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Arithmetic codes assume m=0, logic codes assume m=1.
   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;
   localparam logic [3:0] S_AND = 4'b1011;
   localparam logic [3:0] S_XOR = 4'b0110;

endpackage

// File: rtl/alu181_carry.sv
// Carry-out of one 74181 nibble, built from the same p/g terms as the slice.
module alu181_carry (
   input  logic [3:0] s_i,
   input  logic       ci_i,
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic       cn4_o
);

   logic [3:0] p, g;

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         p[j] = ~(a_i[j] | (s_i[0] & b_i[j]) | (s_i[1] & ~b_i[j]));
         g[j] = ~((s_i[2] & a_i[j] & ~b_i[j]) | (s_i[3] & a_i[j] & b_i[j]));
      end
      cn4_o = ~((~ci_i & g[0] & g[1] & g[2] & g[3]) | p[3] | (p[2] & g[3]) |
                (p[1] & g[2] & g[3]) | (p[0] & g[1] & g[2] & g[3]));
   end

endmodule

// File: rtl/alu74181.sv
// Combinational 4-bit 74181 slice, active-high data and active-high carry in.
module alu74181 (
   input  logic [3:0] s_i,
   input  logic       m_i,
   input  logic       ci_i,
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [3:0] y_o
);

   logic [3:0] p, g, c;

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         p[j] = ~(a_i[j] | (s_i[0] & b_i[j]) | (s_i[1] & ~b_i[j]));
         g[j] = ~((s_i[2] & a_i[j] & ~b_i[j]) | (s_i[3] & a_i[j] & b_i[j]));
      end
      // p is an active-high kill, ~g an active-high generate.
      c[0] = ci_i;
      c[1] = ~(p[0] | (g[0] & ~c[0]));
      c[2] = ~(p[1] | (g[1] & ~c[1]));
      c[3] = ~(p[2] | (g[2] & ~c[2]));
      y_o  = ~(p ^ g) ^ ({4{~m_i}} & ~c);
   end

endmodule

// File: rtl/alu181_nibble_seq.sv
// Runs a (4*NIBBLES)-bit 74181 operation through one slice, one nibble per clock, LSB first.
module alu181_nibble_seq
   import alu181_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic [3:0]             s_i,
   input  logic                   m_i,
   input  logic                   ci_i,
   input  logic [4*NIBBLES-1:0]   a_i,
   input  logic [4*NIBBLES-1:0]   b_i,
   output logic                   ready_o,
   output logic                   done_o,
   output logic [4*NIBBLES-1:0]   y_o,
   output logic                   co_o,
   output logic                   zero_o
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES + 1);

   state_e             state_q, state_d;
   logic [3:0]         s_q, s_d;
   logic               m_q, m_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, y_q, y_d;
   logic               carry_q, carry_d;
   logic               co_q, co_d, zero_q, zero_d;
   logic [IDX_W-1:0]   idx_q, idx_d;

   logic [3:0]         a_nib, b_nib, slice_y;
   logic               slice_ci, cn4;

   assign a_nib    = 4'(a_q >> {idx_q, 2'b00});
   assign b_nib    = 4'(b_q >> {idx_q, 2'b00});
   assign slice_ci = carry_q & ~m_q;

   alu74181 u_slice (
      .s_i  (s_q),
      .m_i  (m_q),
      .ci_i (slice_ci),
      .a_i  (a_nib),
      .b_i  (b_nib),
      .y_o  (slice_y)
   );

   alu181_carry u_carry (
      .s_i   (s_q),
      .ci_i  (slice_ci),
      .a_i   (a_nib),
      .b_i   (b_nib),
      .cn4_o (cn4)
   );

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      m_d     = m_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      carry_d = carry_q;
      co_d    = co_q;
      zero_d  = zero_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               s_d     = s_i;
               m_d     = m_i;
               a_d     = a_i;
               b_d     = b_i;
               carry_d = ci_i;
               idx_d   = '0;
               y_d     = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int k = 0; k < NIBBLES; k++) begin
               if (idx_q == IDX_W'(k)) y_d[4*k +: 4] = slice_y;
            end
            carry_d = cn4 & ~m_q;
            idx_d   = idx_q + IDX_W'(1);
            // Flags capture the completed word on the same edge as the last nibble.
            if (idx_q == IDX_W'(NIBBLES - 1)) begin
               co_d    = cn4 & ~m_q;
               zero_d  = (y_d == '0);
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         m_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         zero_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         m_q     <= m_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         zero_q  <= zero_d;
         idx_q   <= idx_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign done_o  = (state_q == ST_DONE);
   assign y_o     = y_q;
   assign co_o    = co_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Directed + random checks of the nibble-serial 74181 sequencer against a word-level model.
module tb_alu181_nibble_seq;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [3:0]    s_i;
   logic          m_i;
   logic          ci_i;
   logic [W-1:0]  a_i, b_i;
   logic          ready_o, done_o, co_o, zero_o;
   logic [W-1:0]  y_o;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   alu181_nibble_seq #(.NIBBLES(NIBBLES)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .s_i     (s_i),
      .m_i     (m_i),
      .ci_i    (ci_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .ready_o (ready_o),
      .done_o  (done_o),
      .y_o     (y_o),
      .co_o    (co_o),
      .zero_o  (zero_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word-level behaviour: logic table from the 74181 datasheet, arithmetic as plain addition.
   function automatic logic [W:0] ref_op(input logic [3:0] s, input logic m, input logic ci,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r, op2;
      if (m) begin
         case (s)
            4'b0000: r = ~a;
            4'b0001: r = ~(a | b);
            4'b0010: r = ~a & b;
            4'b0011: r = '0;
            4'b0100: r = ~(a & b);
            4'b0101: r = ~b;
            4'b0110: r = a ^ b;
            4'b0111: r = a & ~b;
            4'b1000: r = ~a | b;
            4'b1001: r = ~(a ^ b);
            4'b1010: r = b;
            4'b1011: r = a & b;
            4'b1100: r = '1;
            4'b1101: r = a | ~b;
            4'b1110: r = a | b;
            default: r = a;
         endcase
         return {1'b0, r};
      end
      case (s)
         4'b1001: op2 = b;
         4'b0110: op2 = ~b;
         4'b1100: op2 = a;
         4'b0000: op2 = '0;
         default: op2 = '1;
      endcase
      return {1'b0, a} + {1'b0, op2} + (W+1)'(ci);
   endfunction

   task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic ci,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
      logic [W:0] exp;
      int t;
      exp = ref_op(s, m, ci, a, b);
      t = 0;
      while (!ready_o && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk({tag, "/ready_idle"}, 32'(ready_o), 32'd1);
      s_i = s; m_i = m; ci_i = ci; a_i = a; b_i = b;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk({tag, "/ready_run"}, 32'(ready_o), 32'd0);
      for (int k = 1; k < NIBBLES; k++) begin
         if (poke) begin
            start_i = 1'b1;
            s_i = 4'($urandom); m_i = 1'($urandom);
            a_i = W'($urandom); b_i = W'($urandom);
         end
         @(posedge clk); #1;
         if (done_o) chk({tag, "/done_early"}, 32'(done_o), 32'd0);
      end
      @(posedge clk); #1;
      chk({tag, "/done"}, 32'(done_o), 32'd1);
      chk({tag, "/y"}, 32'(y_o), 32'(exp[W-1:0]));
      chk({tag, "/co"}, 32'(co_o), 32'(exp[W]));
      chk({tag, "/zero"}, 32'(zero_o), 32'(exp[W-1:0] == '0));
      @(posedge clk); #1;
      start_i = 1'b0;
      chk({tag, "/ready_back"}, 32'({ready_o, done_o}), 32'b10);
      chk({tag, "/y_hold"}, 32'(y_o), 32'(exp[W-1:0]));
   endtask

   logic [3:0] arith_s [5] = '{4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b1111};

   initial begin
      int t0, t1;
      bit seen;
      logic [3:0] rs;
      logic rm;

      rst_n = 1'b0; start_i = 1'b0; s_i = '0; m_i = 1'b0; ci_i = 1'b0; a_i = '0; b_i = '0;
      #12;
      chk("rst/ready", 32'(ready_o), 32'd1);
      chk("rst/done", 32'(done_o), 32'd0);
      chk("rst/y", 32'(y_o), 32'd0);
      chk("rst/co", 32'(co_o), 32'd0);
      chk("rst/zero", 32'(zero_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add", 4'b1001, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0);
      chk("add/lit", 32'({co_o, zero_o, y_o}), 32'({1'b0, 1'b0, 16'h0100}));
      run_op("addwrap", 4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 0);
      chk("addwrap/lit", 32'({co_o, zero_o, y_o}), 32'({1'b1, 1'b1, 16'h0000}));
      run_op("sub1", 4'b0110, 1'b0, 1'b1, 16'h1000, 16'h0001, 0);
      chk("sub1/lit", 32'({co_o, y_o}), 32'({1'b1, 16'h0FFF}));
      run_op("sub2", 4'b0110, 1'b0, 1'b1, 16'h0001, 16'h0002, 0);
      chk("sub2/lit", 32'({co_o, y_o}), 32'({1'b0, 16'hFFFF}));
      run_op("and", 4'b1011, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, 0);
      chk("and/lit", 32'({co_o, y_o}), 32'({1'b0, 16'hF000}));
      run_op("xor", 4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 0);
      chk("xor/lit", 32'({co_o, y_o}), 32'({1'b0, 16'h0FF0}));

      // start pulses and operand changes during RUN/DONE must not disturb the op
      run_op("poke", 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FCD, 1);
      @(posedge clk); #1;
      chk("poke/no_accept", 32'(ready_o), 32'd1);

      // start held high: one accept every NIBBLES+2 cycles
      s_i = 4'b1001; m_i = 1'b0; ci_i = 1'b0; a_i = 16'h0102; b_i = 16'h0304;
      start_i = 1'b1;
      t0 = 0;
      for (int k = 0; k < 3; k++) begin
         seen = 0;
         for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk); #1;
            if (done_o) seen = 1;
         end
         chk("held/done_seen", 32'(seen), 32'd1);
         chk("held/y", 32'(y_o), 32'h0406);
         chk("held/ready_in_done", 32'(ready_o), 32'd0);
         t1 = cyc;
         if (k > 0) chk("held/period", 32'(t1 - t0), 32'(NIBBLES + 2));
         t0 = t1;
      end
      start_i = 1'b0;
      @(posedge clk); #1;

      // reset in the cycle after accept aborts with no done
      s_i = 4'b1001; m_i = 1'b0; ci_i = 1'b1; a_i = 16'hFFFF; b_i = 16'h0000;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("abort/ready", 32'(ready_o), 32'd1);
      chk("abort/y", 32'({done_o, co_o, zero_o, y_o}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int t = 0; t < NIBBLES + 3; t++) begin
         @(posedge clk); #1;
         if (done_o) seen = 1;
      end
      chk("abort/no_done", 32'(seen), 32'd0);
      run_op("after_abort", 4'b1001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 0);

      for (int i = 0; i < 60; i++) begin
         rm = 1'($urandom);
         rs = rm ? 4'($urandom) : arith_s[$urandom_range(0, 4)];
         run_op("rand", rs, rm, 1'($urandom), W'($urandom), W'($urandom), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
